// File: rtl/exec_mem_seq_pkg.sv
// Shared state encoding and byte-lane select constants for the exec-stage memory sequencer.
package exec_mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CYC1 = 2'd1,
        CYC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SEL_LO = 2'b01;
    localparam logic [1:0] SEL_HI = 2'b10;
    localparam logic [1:0] SEL_W  = 2'b11;

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering: lane select, write-byte mirroring and read-lane extraction.
module mem_lane_steer
    import exec_mem_seq_pkg::*;
(
    input  logic        second,
    input  logic        byteop,
    input  logic        a0,
    input  logic [15:0] wr_data,
    input  logic [15:0] bus_dat_i,
    output logic [1:0]  sel,
    output logic [15:0] dat_o,
    output logic [15:0] rd_lanes
);

    logic       wide;
    logic [7:0] wr_byte;
    logic [7:0] rd_byte;

    assign wide = !byteop && !a0;

    always_comb begin
        sel = SEL_LO;
        if (second)
            sel = SEL_LO;
        else if (wide)
            sel = SEL_W;
        else if (a0)
            sel = SEL_HI;
    end

    // Single-byte cycles mirror the byte onto both lanes so the slave can take either one.
    assign wr_byte  = second ? wr_data[15:8] : wr_data[7:0];
    assign dat_o    = (wide && !second) ? wr_data : {wr_byte, wr_byte};
    assign rd_byte  = (sel == SEL_HI) ? bus_dat_i[15:8] : bus_dat_i[7:0];
    assign rd_lanes = wide ? bus_dat_i : {8'h00, rd_byte};

endmodule

// File: rtl/exec_mem_seq.sv
// Memory/IO access sequencer: runs strobe/ack bus cycles for exec accesses, splitting unaligned words.
// Defining BUS_TIMEOUT_EN builds the ack-timeout abort; otherwise the sequencer waits for ack forever.
module exec_mem_seq
    import exec_mem_seq_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              m_io,
    input  logic              byteop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wr_data,
    output logic              mem_rdy,
    output logic [15:0]       rd_data,
    output logic              bus_stb,
    output logic              bus_we,
    output logic              bus_io,
    output logic [ADDR_W-2:0] bus_adr,
    output logic [1:0]        bus_sel,
    output logic [15:0]       bus_dat_o,
    input  logic [15:0]       bus_dat_i,
    input  logic              bus_ack,
    output logic              bus_to
);

    localparam logic [ADDR_W-2:0] ADR_ONE = (ADDR_W-1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic              we_q;
    logic              io_q;
    logic              byteop_q;
    logic              split_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wr_data_q;
    logic [15:0]       rd_data_q;
    logic              second;
    logic [1:0]        sel;
    logic [15:0]       dat;
    logic [15:0]       rd_lanes;
    logic              expire;

    assign second  = (state == CYC2);
    assign bus_stb = (state == CYC1) || second;

    mem_lane_steer u_steer (
        .second    (second),
        .byteop    (byteop_q),
        .a0        (addr_q[0]),
        .wr_data   (wr_data_q),
        .bus_dat_i (bus_dat_i),
        .sel       (sel),
        .dat_o     (dat),
        .rd_lanes  (rd_lanes)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             to_q;

    // Counts strobe cycles since the last ack; each bus cycle gets a fresh budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            to_q    <= 1'b0;
        end else begin
            if (!bus_stb || bus_ack)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (bus_stb)
                to_q <= expire;
        end
    end

    assign expire = bus_stb && !bus_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign bus_to = (state == DONE) && to_q;
`else
    localparam int timeout_unused = TIMEOUT;

    assign expire = 1'b0;
    assign bus_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = CYC1;
            CYC1: begin
                if (bus_ack)
                    state_nxt = split_q ? CYC2 : DONE;
                else if (expire)
                    state_nxt = DONE;
            end
            CYC2: if (bus_ack || expire) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The access is latched once in IDLE so exec may change its inputs after mem_rdy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            io_q      <= 1'b0;
            byteop_q  <= 1'b0;
            split_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= 16'h0000;
            rd_data_q <= 16'h0000;
        end else begin
            if (state == IDLE && req) begin
                we_q      <= we;
                io_q      <= m_io;
                byteop_q  <= byteop;
                addr_q    <= addr;
                wr_data_q <= wr_data;
                split_q   <= !byteop && addr[0];
            end
            if (bus_stb && bus_ack && !we_q) begin
                if (second)
                    rd_data_q[15:8] <= rd_lanes[7:0];
                else
                    rd_data_q <= rd_lanes;
            end else if (expire) begin
                rd_data_q <= 16'hFFFF;
            end
        end
    end

    assign mem_rdy   = (state == DONE);
    assign rd_data   = rd_data_q;
    assign bus_we    = bus_stb && we_q;
    assign bus_io    = bus_stb && io_q;
    assign bus_sel   = bus_stb ? sel : 2'b00;
    assign bus_dat_o = bus_stb ? dat : 16'h0000;
    assign bus_adr   = !bus_stb ? '0 :
                       second   ? addr_q[ADDR_W-1:1] + ADR_ONE : addr_q[ADDR_W-1:1];

endmodule

// File: tb/tb_exec_mem_seq.sv
// Scoreboard bench for exec_mem_seq: directed and random accesses checked against a byte-addressed memory model.
module tb_exec_mem_seq;

    localparam int ADDR_W  = 20;
    localparam int TIMEOUT = 8;
    localparam int AMASK   = (1 << ADDR_W) - 1;
    localparam logic [ADDR_W-2:0] ADR_ONE = (ADDR_W-1)'(1);

    typedef struct packed {
        logic [ADDR_W-2:0] adr;
        logic [1:0]        sel;
        logic [15:0]       dat;
        logic              we;
        logic              io;
    } cyc_t;

    typedef struct packed {
        logic        rd;
        logic        to;
        logic [15:0] data;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic              m_io = 1'b0;
    logic              byteop = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [15:0]       wr_data = 16'h0000;
    logic              mem_rdy;
    logic [15:0]       rd_data;
    logic              bus_stb;
    logic              bus_we;
    logic              bus_io;
    logic [ADDR_W-2:0] bus_adr;
    logic [1:0]        bus_sel;
    logic [15:0]       bus_dat_o;
    logic [15:0]       bus_dat_i = 16'h0000;
    logic              bus_ack = 1'b0;
    logic              bus_to;

    int n_checks = 0;
    int n_pass = 0;
    int forced_waits = -1;

    cyc_t exp_cyc[$];
    rsp_t exp_rsp[$];
    logic [7:0] ref_mem [int];
    logic [7:0] bus_mem [int];

    exec_mem_seq #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .m_io      (m_io),
        .byteop    (byteop),
        .addr      (addr),
        .wr_data   (wr_data),
        .mem_rdy   (mem_rdy),
        .rd_data   (rd_data),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_io    (bus_io),
        .bus_adr   (bus_adr),
        .bus_sel   (bus_sel),
        .bus_dat_o (bus_dat_o),
        .bus_dat_i (bus_dat_i),
        .bus_ack   (bus_ack),
        .bus_to    (bus_to)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [7:0] init_byte(int a);
        return 8'((a * 37) ^ (a >> 7) ^ 'h5A);
    endfunction

    function automatic logic [7:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] bus_rd(int a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction

    function automatic void set_byte(int a, logic [7:0] v);
        ref_mem[a] = v;
        bus_mem[a] = v;
    endfunction

    // Reference: a byte-addressed little-endian memory; an access touches byte a (and a+1 for words).
    function automatic int modelAccess(logic w, logic io, logic bo, logic [ADDR_W-1:0] a, logic [15:0] d);
        int lo = int'(a);
        int hi = (lo + 1) & AMASK;
        logic [ADDR_W-2:0] wa = a[ADDR_W-1:1];
        rsp_t r;
        if (bo) begin
            exp_cyc.push_back('{wa, a[0] ? 2'b10 : 2'b01, {d[7:0], d[7:0]}, w, io});
            if (w) ref_mem[lo] = d[7:0];
            r = '{!w, 1'b0, {8'h00, ref_rd(lo)}};
        end else begin
            if (!a[0]) begin
                exp_cyc.push_back('{wa, 2'b11, d, w, io});
            end else begin
                exp_cyc.push_back('{wa, 2'b10, {d[7:0], d[7:0]}, w, io});
                exp_cyc.push_back('{wa + ADR_ONE, 2'b01, {d[15:8], d[15:8]}, w, io});
            end
            if (w) begin
                ref_mem[lo] = d[7:0];
                ref_mem[hi] = d[15:8];
            end
            r = '{!w, 1'b0, {ref_rd(hi), ref_rd(lo)}};
        end
        exp_rsp.push_back(r);
        return (bo || !a[0]) ? 1 : 2;
    endfunction

    task automatic applyStimulus(input logic w, input logic io, input logic bo,
                                 input logic [ADDR_W-1:0] a, input logic [15:0] d,
                                 input bit keep, input bit expect_to);
        int  ncyc;
        int  cnt;
        int  lat;
        bit  was_held;
        was_held = req;
        if (!was_held) begin
            @(posedge clk);
            #1;
        end
        if (expect_to) begin
            exp_rsp.push_back('{1'b1, 1'b1, 16'hFFFF});
            lat = 1 + TIMEOUT;
        end else begin
            ncyc = modelAccess(w, io, bo, a, d);
            lat  = (forced_waits >= 0) ? 1 + ncyc * (1 + forced_waits) : -1;
        end
        if (was_held) lat = -1;
        we = w;
        m_io = io;
        byteop = bo;
        addr = a;
        wr_data = d;
        req = 1'b1;
        cnt = 0;
        while (cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (mem_rdy) break;
        end
        if (!mem_rdy) begin
            $display("[TB] FAIL rdy_wait: mem_rdy not seen after %0d cycles, expected within 2000", cnt);
            $display("%0d/%0d checks passed", n_pass, n_checks + 1);
            $fatal(1, "[TB] access stalled");
        end
        if (lat >= 0) checkOutput("latency", cnt, lat);
        if (!keep) req = 1'b0;
    endtask

    // Bus slave: random wait states, junk on unselected lanes, writes land in its own memory.
    initial begin
        int wait_left;
        bit in_cyc;
        int a;
        wait_left = 0;
        in_cyc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_ack) begin
                bus_ack = 1'b0;
                in_cyc = 1'b0;
            end
            bus_dat_i = 16'($urandom);
            if (rst && bus_stb) begin
                if (!in_cyc) begin
                    in_cyc = 1'b1;
                    wait_left = (forced_waits >= 0) ? forced_waits : int'($urandom_range(0, 3));
                end
                if (wait_left == 0) begin
                    a = int'({bus_adr, 1'b0});
                    if (bus_sel[0]) bus_dat_i[7:0]  = bus_rd(a);
                    if (bus_sel[1]) bus_dat_i[15:8] = bus_rd(a + 1);
                    if (bus_we) begin
                        if (bus_sel[0]) bus_mem[a]     = bus_dat_o[7:0];
                        if (bus_sel[1]) bus_mem[a + 1] = bus_dat_o[15:8];
                    end
                    bus_ack = 1'b1;
                end else begin
                    wait_left--;
                end
            end else begin
                in_cyc = 1'b0;
            end
        end
    end

    // Monitor: pops an expected bus cycle on every acked strobe and an expected response on every mem_rdy.
    initial begin
        cyc_t c;
        rsp_t r;
        bit   prev_rdy;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_rdy = 1'b0;
                continue;
            end
            if (bus_stb && bus_ack) begin
                checkOutput("cyc_expected", exp_cyc.size() > 0, 1);
                if (exp_cyc.size() > 0) begin
                    c = exp_cyc.pop_front();
                    checkOutput("bus_adr", bus_adr, c.adr);
                    checkOutput("bus_sel", bus_sel, c.sel);
                    checkOutput("bus_we", bus_we, c.we);
                    checkOutput("bus_io", bus_io, c.io);
                    if (c.we) checkOutput("bus_dat_o", bus_dat_o, c.dat);
                end
            end
            if (mem_rdy) begin
                checkOutput("mem_rdy_pulse", prev_rdy, 0);
                checkOutput("rsp_expected", exp_rsp.size() > 0, 1);
                if (exp_rsp.size() > 0) begin
                    r = exp_rsp.pop_front();
                    if (r.rd) checkOutput("rd_data", rd_data, r.data);
                    checkOutput("bus_to", bus_to, r.to);
                end
            end
            prev_rdy = mem_rdy;
        end
    end

    initial begin
        int guard;
        logic [ADDR_W-1:0] ra;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_bus_stb", bus_stb, 0);
        checkOutput("rst_mem_rdy", mem_rdy, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_bus_adr", bus_adr, 0);
        checkOutput("rst_bus_sel", bus_sel, 0);
        checkOutput("rst_bus_dat_o", bus_dat_o, 0);
        checkOutput("rst_bus_we_io_to", {bus_we, bus_io, bus_to}, 0);
        rst = 1'b1;

        forced_waits = 2;
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h01234, 16'hBEEF, 1'b0, 1'b0);

        set_byte(32'h11, 8'h34);
        set_byte(32'h12, 8'h12);
        forced_waits = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 20'h00011, 16'h0000, 1'b0, 1'b0);
        checkOutput("split_rd_value", rd_data, 16'h1234);

        forced_waits = 1;
        applyStimulus(1'b1, 1'b0, 1'b1, 20'h00005, 16'h00AB, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 20'h00005, 16'h0000, 1'b0, 1'b0);
        checkOutput("byte_rd_value", rd_data, 16'h00AB);

        forced_waits = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 20'hFFFFF, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 20'hFFFFF, 16'hC3A5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 20'hFFFFF, 16'h0000, 1'b0, 1'b0);

        forced_waits = -1;
        applyStimulus(1'b1, 1'b1, 1'b0, 20'h00100, 16'h5A5A, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 20'h00100, 16'h0000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the second half of a split read.
        forced_waits = 3;
        @(posedge clk);
        #1;
        void'(modelAccess(1'b0, 1'b0, 1'b0, 20'h00021, 16'h0000));
        we = 1'b0;
        m_io = 1'b0;
        byteop = 1'b0;
        addr = 20'h00021;
        req = 1'b1;
        guard = 0;
        while (!(bus_stb && bus_sel == 2'b01) && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("reached_cyc2", bus_stb && bus_sel == 2'b01, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_stb", bus_stb, 0);
        checkOutput("async_rst_rdy", mem_rdy, 0);
        checkOutput("async_rst_sel", bus_sel, 0);
        exp_cyc.delete();
        exp_rsp.delete();
        req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_idle", {bus_stb, mem_rdy}, 0);
        end
        forced_waits = -1;
        applyStimulus(1'b0, 1'b0, 1'b0, 20'h00021, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            forced_waits = ($urandom_range(0, 3) == 0) ? 0 : -1;
            ra = ($urandom_range(0, 1) == 1) ? 20'($urandom_range(0, 31))
                                             : 20'hFFFE0 + 20'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ra, 16'($urandom), (i % 8) == 5, 1'b0);
        end

`ifdef BUS_TIMEOUT_EN
        forced_waits = 100000;
        applyStimulus(1'b0, 1'b0, 1'b0, 20'h00040, 16'h0000, 1'b0, 1'b1);
        forced_waits = -1;
        applyStimulus(1'b0, 1'b0, 1'b0, 20'h00041, 16'h0000, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("cyc_queue_empty", exp_cyc.size(), 0);
        checkOutput("rsp_queue_empty", exp_rsp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
